// File: rtl/shift_seq_ctrl_dlx_if.sv
// Request/response bundle between the DLX execute stage (master) and the
// shift sequencer (slave). arith exists only when SHIFT_SEQ_ARITH_EN is defined.
interface shift_seq_ctrl_dlx_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
);
    logic             start;
    logic             right;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;
`ifdef SHIFT_SEQ_ARITH_EN
    logic             arith;
`endif

    modport master (
`ifdef SHIFT_SEQ_ARITH_EN
        output arith,
`endif
        output start, right, amount, din,
        input  busy, done, dout
    );

    modport slave (
`ifdef SHIFT_SEQ_ARITH_EN
        input  arith,
`endif
        input  start, right, amount, din,
        output busy, done, dout
    );
endinterface

// File: rtl/shift_seq_ctrl_dlx.sv
// Multi-cycle SLL/SRL sequencer around the shared 1-bit DLX shifter.
// Define SHIFT_SEQ_ARITH_EN to add the arith input (sign-replicating right shifts).
//
// state | meaning
// IDLE  | waiting for start; operands latched when it arrives
// SHIFT | one single-bit shift per clock, cnt counts down to 1
// DONE  | dout valid, done pulses for one cycle, then back to IDLE
module shift_seq_ctrl_dlx #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    shift_seq_ctrl_dlx_if.slave   bus,
    output logic [WIDTH-1:0]      sh_di,
    output logic                  sh_shift,
    output logic                  sh_right,
    input  logic [WIDTH-1:0]      sh_do
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data, data_nxt;
    logic [WIDTH-1:0] dout_q, dout_nxt;
    logic [AMT_W-1:0] cnt, cnt_nxt;
    logic             dir, dir_nxt;
    logic [WIDTH-1:0] shifted;
`ifdef SHIFT_SEQ_ARITH_EN
    logic             ar, ar_nxt;
`endif

    assign sh_di    = data;
    assign bus.dout = dout_q;

`ifdef SHIFT_SEQ_ARITH_EN
    // The shared shifter always zero-fills; restore the sign bit for SRA.
    assign shifted = (dir && ar) ? {data[WIDTH-1], sh_do[WIDTH-2:0]} : sh_do;
`else
    assign shifted = sh_do;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            data   <= '0;
            dout_q <= '0;
            cnt    <= '0;
            dir    <= 1'b0;
`ifdef SHIFT_SEQ_ARITH_EN
            ar     <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            data   <= data_nxt;
            dout_q <= dout_nxt;
            cnt    <= cnt_nxt;
            dir    <= dir_nxt;
`ifdef SHIFT_SEQ_ARITH_EN
            ar     <= ar_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data;
        dout_nxt  = dout_q;
        cnt_nxt   = cnt;
        dir_nxt   = dir;
`ifdef SHIFT_SEQ_ARITH_EN
        ar_nxt    = ar;
`endif
        sh_shift  = 1'b0;
        sh_right  = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    data_nxt = bus.din;
                    cnt_nxt  = bus.amount;
                    dir_nxt  = bus.right;
`ifdef SHIFT_SEQ_ARITH_EN
                    ar_nxt   = bus.arith;
`endif
                    // dout is loaded on entry to DONE so it is valid alongside done.
                    if (bus.amount == '0) begin
                        dout_nxt  = bus.din;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                bus.busy = 1'b1;
                sh_shift = 1'b1;
                sh_right = dir;
                data_nxt = shifted;
                cnt_nxt  = cnt - AMT_W'(1);
                if (cnt == AMT_W'(1)) begin
                    dout_nxt  = shifted;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.busy  = 1'b1;
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_shift_seq_ctrl_dlx.sv
// Scoreboard bench for shift_seq_ctrl_dlx with a behavioural 1-bit shifter.
// Define SHIFT_SEQ_ARITH_EN to also exercise arithmetic right shifts.
module tb_shift_seq_ctrl_dlx;
    localparam int W = 32;
    localparam int A = 5;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] sh_di, sh_do;
    logic         sh_shift, sh_right;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    shift_seq_ctrl_dlx_if #(.WIDTH(W), .AMT_W(A)) bus_if ();

    // Stand-in for the shared DLX shifter: zero-fill, pass-through when idle.
    assign sh_do = sh_shift ? (sh_right ? (sh_di >> 1) : (sh_di << 1)) : sh_di;

    shift_seq_ctrl_dlx #(.WIDTH(W), .AMT_W(A)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if),
        .sh_di    (sh_di),
        .sh_shift (sh_shift),
        .sh_right (sh_right),
        .sh_do    (sh_do)
    );

    always @(negedge clk) if (bus_if.done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int amt,
                                            input bit r, input bit ar);
        logic [W-1:0] v;
        v = d;
        for (int i = 0; i < amt; i++) begin
            if (!r)      v = v << 1;
            else if (ar) v = {v[W-1], v[W-1:1]};
            else         v = v >> 1;
        end
        return v;
    endfunction

    // Drive one request so the start edge is the next rising edge; returns 1 ns after it.
    task automatic issue(input logic [W-1:0] d, input int amt, input bit r, input bit ar);
        @(negedge clk);
        bus_if.din    = d;
        bus_if.amount = amt[A-1:0];
        bus_if.right  = r;
`ifdef SHIFT_SEQ_ARITH_EN
        bus_if.arith  = ar;
`endif
        bus_if.start  = 1'b1;
        exp_q.push_back(model(d, amt, r, ar));
        @(posedge clk);
        #1 bus_if.start = 1'b0;
    endtask

    // Observes cycles k0.. after the start edge at each falling edge until done.
    task automatic wait_done(input int k0, input int budget, output int lat,
                             output int shifts, output bit seen);
        seen = 1'b0; shifts = 0; lat = 0;
        for (int k = k0; k < k0 + budget; k++) begin
            @(negedge clk);
            if (sh_shift === 1'b1) shifts++;
            if (bus_if.done === 1'b1) begin
                seen = 1'b1;
                lat  = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat, shifts; bit seen; logic [W-1:0] e;
        reset_n = 1'b0;
        bus_if.start = 1'b1; bus_if.din = 32'hFFFF_FFFF; bus_if.amount = 5'd5; bus_if.right = 1'b0;
`ifdef SHIFT_SEQ_ARITH_EN
        bus_if.arith = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus_if.busy); end
        n_checks++; if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus_if.done); end
        n_checks++; if (bus_if.dout !== 32'h0) begin n_fail++; $display("FAIL rst_dout: got %h want 0", bus_if.dout); end
        n_checks++; if (sh_shift !== 1'b0) begin n_fail++; $display("FAIL rst_sh_shift: got %b want 0", sh_shift); end
        n_checks++; if (sh_di !== 32'h0) begin n_fail++; $display("FAIL rst_sh_di: got %h want 0", sh_di); end
        bus_if.start = 1'b0;
        reset_n = 1'b1;
        issue(32'h0000_0001, 4, 1'b0, 1'b0);
        wait_done(1, 40, lat, shifts, seen);
        e = exp_q.pop_front();
        n_checks++; if (!seen) begin n_fail++; $display("FAIL first_done_timeout: no done within budget"); end
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL first_latency: got %0d want 5", lat); end
        n_checks++; if (shifts != 4) begin n_fail++; $display("FAIL first_shifts: got %0d want 4", shifts); end
        n_checks++; if (bus_if.dout !== e) begin n_fail++; $display("FAIL first_dout: got %h want %h", bus_if.dout, e); end
        @(negedge clk);
        n_checks++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0)
            begin n_fail++; $display("FAIL first_after_done: busy=%b done=%b want 0 0", bus_if.busy, bus_if.done); end
    endtask

    task automatic test_right_shift();
        int lat, shifts; bit seen; logic [W-1:0] e;
        issue(32'h8000_0000, 31, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++; if (sh_shift !== 1'b1 || sh_right !== 1'b1)
            begin n_fail++; $display("FAIL sr_drive: sh_shift=%b sh_right=%b want 1 1", sh_shift, sh_right); end
        n_checks++; if (bus_if.dout !== 32'h0000_0010)
            begin n_fail++; $display("FAIL sr_dout_hold: got %h want 00000010", bus_if.dout); end
        wait_done(2, 60, lat, shifts, seen);
        e = exp_q.pop_front();
        n_checks++; if (!seen) begin n_fail++; $display("FAIL sr_timeout: no done within budget"); end
        n_checks++; if (lat != 32) begin n_fail++; $display("FAIL sr_latency: got %0d want 32", lat); end
        n_checks++; if (shifts + 1 != 31) begin n_fail++; $display("FAIL sr_shifts: got %0d want 31", shifts + 1); end
        n_checks++; if (bus_if.dout !== e) begin n_fail++; $display("FAIL sr_dout: got %h want %h", bus_if.dout, e); end
    endtask

    task automatic test_zero_amount();
        int lat, shifts; bit seen; logic [W-1:0] e;
        issue(32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        wait_done(1, 5, lat, shifts, seen);
        e = exp_q.pop_front();
        n_checks++; if (!seen || lat != 1) begin n_fail++; $display("FAIL zero_latency: seen=%b got %0d want 1", seen, lat); end
        n_checks++; if (shifts != 0) begin n_fail++; $display("FAIL zero_shifts: got %0d want 0", shifts); end
        n_checks++; if (bus_if.dout !== e) begin n_fail++; $display("FAIL zero_dout: got %h want %h", bus_if.dout, e); end
        @(negedge clk);
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_fall: got %b want 0", bus_if.busy); end
    endtask

    task automatic test_busy_ignore();
        int lat, shifts, d0; bit seen; logic [W-1:0] e;
        d0 = done_cnt;
        issue(32'h0000_00F1, 3, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL busy_high: got %b want 1", bus_if.busy); end
        bus_if.start = 1'b1; bus_if.din = 32'hFFFF_FFFF; bus_if.right = 1'b1; bus_if.amount = 5'd7;
        @(posedge clk);
        #1 bus_if.start = 1'b0;
        wait_done(2, 20, lat, shifts, seen);
        e = exp_q.pop_front();
        n_checks++; if (!seen || lat != 4) begin n_fail++; $display("FAIL busy_latency: seen=%b got %0d want 4", seen, lat); end
        n_checks++; if (bus_if.dout !== e) begin n_fail++; $display("FAIL busy_dout: got %h want %h", bus_if.dout, e); end
        repeat (4) @(negedge clk);
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL busy_done_count: got %0d want 1", done_cnt - d0); end
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle: got %b want 0", bus_if.busy); end
    endtask

    task automatic test_abort();
        int lat, shifts, d0; bit seen; logic [W-1:0] e;
        issue(32'hF0F0_F0F0, 8, 1'b0, 1'b0);
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        n_checks++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0)
            begin n_fail++; $display("FAIL abort_flags: busy=%b done=%b want 0 0", bus_if.busy, bus_if.done); end
        n_checks++; if (bus_if.dout !== 32'h0) begin n_fail++; $display("FAIL abort_dout: got %h want 0", bus_if.dout); end
        n_checks++; if (sh_shift !== 1'b0) begin n_fail++; $display("FAIL abort_sh_shift: got %b want 0", sh_shift); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (done_cnt != d0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0); end
        issue(32'h0000_0001, 1, 1'b0, 1'b0);
        wait_done(1, 10, lat, shifts, seen);
        e = exp_q.pop_front();
        n_checks++; if (!seen || lat != 2) begin n_fail++; $display("FAIL post_abort_latency: seen=%b got %0d want 2", seen, lat); end
        n_checks++; if (bus_if.dout !== e) begin n_fail++; $display("FAIL post_abort_dout: got %h want %h", bus_if.dout, e); end
    endtask

`ifdef SHIFT_SEQ_ARITH_EN
    task automatic test_arith();
        int lat, shifts; bit seen; logic [W-1:0] e;
        issue(32'h8000_0000, 4, 1'b1, 1'b1);
        wait_done(1, 10, lat, shifts, seen);
        e = exp_q.pop_front();
        n_checks++; if (!seen || bus_if.dout !== e) begin n_fail++; $display("FAIL sra_dout: got %h want %h", bus_if.dout, e); end
        issue(32'h8000_0000, 4, 1'b1, 1'b0);
        wait_done(1, 10, lat, shifts, seen);
        e = exp_q.pop_front();
        n_checks++; if (!seen || bus_if.dout !== e) begin n_fail++; $display("FAIL srl_dout: got %h want %h", bus_if.dout, e); end
        issue(32'h8000_0001, 2, 1'b0, 1'b1);
        wait_done(1, 10, lat, shifts, seen);
        e = exp_q.pop_front();
        n_checks++; if (!seen || bus_if.dout !== e) begin n_fail++; $display("FAIL sll_arith_dout: got %h want %h", bus_if.dout, e); end
    endtask
`endif

    task automatic test_back_to_back();
        int lat, shifts, amt; bit seen, r; logic [W-1:0] d, e;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin d = 32'h0000_0001; amt = 31; r = 1'b0; end
                1: begin d = 32'hFFFF_FFFF; amt = 1;  r = 1'b1; end
                default: begin d = $urandom; amt = $urandom_range(0, 31); r = 1'($urandom_range(0, 1)); end
            endcase
            issue(d, amt, r, 1'b0);
            wait_done(1, 40, lat, shifts, seen);
            e = exp_q.pop_front();
            n_checks++; if (!seen || lat != amt + 1)
                begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, amt + 1); end
            n_checks++; if (bus_if.dout !== e)
                begin n_fail++; $display("FAIL b2b_dout[%0d]: got %h want %h", i, bus_if.dout, e); end
        end
    endtask

    initial begin
        bus_if.start = 1'b0; bus_if.right = 1'b0; bus_if.amount = '0; bus_if.din = '0;
`ifdef SHIFT_SEQ_ARITH_EN
        bus_if.arith = 1'b0;
`endif
        test_reset();
        test_right_shift();
        test_zero_amount();
        test_busy_ignore();
        test_abort();
`ifdef SHIFT_SEQ_ARITH_EN
        test_arith();
`endif
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
